// File: rtl/data_mem_seq_if.sv
// Request/response and byte-memory port bundle for data_mem_sequencer.
// slave = sequencer side, master = pipeline + memory side.
interface data_mem_seq_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_DIR_WIDTH = 8,
  parameter int WORD_WIDTH     = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [1:0]                req_size;
  logic                      req_signed;
  logic [DATA_DIR_WIDTH-1:0] req_addr;
  logic [WORD_WIDTH-1:0]     req_wdata;
  logic                      resp_valid;
  logic [WORD_WIDTH-1:0]     resp_rdata;
  logic                      resp_err;
  logic [DATA_DIR_WIDTH-1:0] mem_Address;
  logic [DATA_WIDTH-1:0]     mem_WriteData;
  logic                      mem_MemWrite;
  logic                      mem_MemRead;
  logic [DATA_WIDTH-1:0]     mem_ReadData;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_ReadData,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_Address, mem_WriteData, mem_MemWrite, mem_MemRead
  );
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_ReadData,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_Address, mem_WriteData, mem_MemWrite, mem_MemRead
  );
endinterface

// File: rtl/data_mem_sequencer.sv
// Splits byte/half/word loads and stores into big-endian byte beats on a byte-wide memory.
// Define DATA_MEM_SEQ_ALIGN_CHECK_EN to flag misaligned requests instead of aligning them down.
module data_mem_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_DIR_WIDTH = 8,
  parameter int WORD_WIDTH     = 32
) (
  input logic           clk,
  input logic           rst,
  data_mem_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_e;

  typedef struct packed {
    logic                      write;
    logic                      sgn;
    logic [1:0]                last;   // beats - 1
    logic [DATA_DIR_WIDTH-1:0] base;
    logic [WORD_WIDTH-1:0]     wdata;
  } req_t;

  localparam int AW = WORD_WIDTH - DATA_WIDTH;

  state_e                    state_q, state_d;
  req_t                      req_q, req_d;
  logic [1:0]                beat_q, beat_d;
  logic [AW-1:0]             asm_q, asm_d;
  logic [WORD_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic [1:0]                last_n, wbyte;
  logic                      mis;
  logic [DATA_DIR_WIDTH-1:0] base_n;
  logic [WORD_WIDTH-1:0]     asm_nxt, load_val;
  logic [DATA_DIR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0]     m_wdata;
  logic                      m_we, m_re;

  always_comb begin
    last_n = (bus.req_size == 2'b00) ? 2'd0 : (bus.req_size == 2'b01) ? 2'd1 : 2'd3;
    mis    = 1'b0;
    base_n = bus.req_addr;
`ifdef DATA_MEM_SEQ_ALIGN_CHECK_EN
    mis = ((last_n == 2'd1) && bus.req_addr[0]) ||
          ((last_n == 2'd3) && (bus.req_addr[1:0] != 2'b00));
`else
    if (last_n == 2'd1) base_n[0]   = 1'b0;
    if (last_n == 2'd3) base_n[1:0] = 2'b00;
`endif
  end

  // Final byte arrives in DRAIN; extension works on the fully shifted value.
  always_comb begin
    asm_nxt = {asm_q, bus.mem_ReadData};
    case (req_q.last)
      2'd0:    load_val = {{(WORD_WIDTH-DATA_WIDTH){req_q.sgn & asm_nxt[DATA_WIDTH-1]}},
                           asm_nxt[DATA_WIDTH-1:0]};
      2'd1:    load_val = {{(WORD_WIDTH-2*DATA_WIDTH){req_q.sgn & asm_nxt[2*DATA_WIDTH-1]}},
                           asm_nxt[2*DATA_WIDTH-1:0]};
      default: load_val = asm_nxt;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    m_addr  = '0;
    m_wdata = '0;
    m_we    = 1'b0;
    m_re    = 1'b0;
    wbyte   = req_q.last - beat_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        req_d.write = bus.req_write;
        req_d.sgn   = bus.req_signed;
        req_d.last  = last_n;
        req_d.base  = base_n;
        req_d.wdata = bus.req_wdata;
        beat_d      = 2'd0;
        asm_d       = '0;
        err_d       = mis;
        if (mis) begin
          rdata_d = '0;
          state_d = RESP;
        end else begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        m_addr = req_q.base + DATA_DIR_WIDTH'(beat_q);
        if (req_q.write) begin
          m_we    = 1'b1;
          m_wdata = req_q.wdata[int'(wbyte)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          m_re = 1'b1;
          if (beat_q != 2'd0) asm_d = asm_nxt[AW-1:0];
        end
        beat_d = beat_q + 2'd1;
        if (beat_q == req_q.last) begin
          if (req_q.write) begin
            rdata_d = '0;
            state_d = RESP;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        asm_d   = asm_nxt[AW-1:0];
        rdata_d = load_val;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      beat_q  <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Gating with rst keeps every output (and any pending strobe) at 0 while reset is held.
  assign bus.req_ready     = rst & (state_q == IDLE);
  assign bus.resp_valid    = rst & (state_q == RESP);
  assign bus.resp_err      = rst & (state_q == RESP) & err_q;
  assign bus.resp_rdata    = rst ? rdata_q : '0;
  assign bus.mem_Address   = rst ? m_addr  : '0;
  assign bus.mem_WriteData = rst ? m_wdata : '0;
  assign bus.mem_MemWrite  = rst & m_we;
  assign bus.mem_MemRead   = rst & m_re;
endmodule

// File: doc/data_mem_sequencer.md
# data_mem_sequencer

- Memory-stage sequencer between the MIPS pipeline's MEM stage and the byte-wide data memory (DataMemory).
- Accepts one byte, halfword or word load/store per request and splits it into sequential byte beats on the memory's Address/WriteData/MemWrite/MemRead port.
- Reassembles read bytes big-endian, sign- or zero-extends them, and returns a single completion pulse.
- Stalls the pipeline through `req_ready` while a request is in flight.

## Interface

Parameters:
- DATA_WIDTH, 8, memory byte width; must be 8.
- DATA_DIR_WIDTH, 8, byte address width.
- WORD_WIDTH, 32, CPU data width; must be 4*DATA_WIDTH.

Ports (all `mem_*` outputs are registered or decoded from registered state only; no combinational path from `req_*`):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  1 only in IDLE with rst high.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_signed  in  1  load sign-extend select.
- req_addr  in  DATA_DIR_WIDTH  byte address.
- req_wdata  in  WORD_WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  WORD_WIDTH  load result; held until next resp_valid.
- resp_err  out  1  misaligned flag; valid with resp_valid.
- mem_Address  out  DATA_DIR_WIDTH  to memory Address.
- mem_WriteData  out  DATA_WIDTH  to memory WriteData.
- mem_MemWrite  out  1  to memory MemWrite.
- mem_MemRead  out  1  to memory MemRead.
- mem_ReadData  in  DATA_WIDTH  from memory; registered there, valid the cycle after a MemRead edge.

## Operation

- States: IDLE, ACCESS, DRAIN, RESP.
- IDLE: `req_valid && req_ready` at an edge latches addr, size, write, signed and wdata. Sets N = 1/2/4 beats and beat = 0.
  - Normal request: goes to ACCESS.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]≠0): goes to RESP with err=1. No memory access is made.
- ACCESS: mem_Address = base+beat, modulo 2^DATA_DIR_WIDTH (wraps FF→00).
  - Store: MemWrite=1, WriteData = byte (N-1-beat) of wdata; byte 0 is the LSB. The MSB goes to the lowest address.
  - Load: MemRead=1. For beat≥1, each edge shifts mem_ReadData into the assembly register, MSB first.
  - beat increments each edge. At beat==N-1 a store goes to RESP and a load goes to DRAIN.
- DRAIN (loads only): MemRead=MemWrite=0. The edge captures the final byte, then goes to RESP.
- RESP: resp_valid=1 for exactly one cycle; err holds the latched flag. Next edge goes to IDLE.
  - Load data is extended from 8/16 bits using the latched signed flag.
  - Store or errored request: resp_rdata = 0.
- Outside ACCESS: MemRead=MemWrite=0, mem_Address=0, mem_WriteData=0.
- Never drive MemWrite and MemRead together.
- rst low at any edge, including mid-request:
  - State returns to IDLE and the request is abandoned with no response.
  - All outputs go to 0; req_ready=0 while rst is low.
  - Memory writes already issued stay done.

## Timing

Cycle 0 is the accept edge; latencies are cycles to the cycle in which resp_valid=1.
- Word load: ACCESS cycles 1–4, DRAIN 5, resp 6.
- Half load: resp 4.
- Byte load: resp 3.
- Word store: ACCESS 1–4, resp 5.
- Half store: resp 3.
- Byte store: resp 2.
- Misaligned request: resp 1.
- req_ready returns to 1 the cycle after resp_valid. Maximum throughput is one word load per 7 cycles.
- req_* inputs are ignored outside the accept edge.

## Configuration

- `DATA_MEM_SEQ_ALIGN_CHECK_EN` defined:
  - The misalignment check above applies; resp_err can be 1.
- Not defined:
  - No alignment check is made and resp_err is tied to 0.
  - The low address bits are forced to 0: addr[0] for half, addr[1:0] for word. The access proceeds at the aligned-down address.

## Test plan

- Reset: hold rst=0 for 3 cycles with req_valid=1 -> all outputs 0, req_ready=0, and no mem strobes.
- Word store then load: store 0xDEADBEEF at addr 0x10 -> MemWrite beats write DE,AD,BE,EF to 0x10–0x13, resp_valid in cycle 5. Load word from 0x10 -> resp_rdata=0xDEADBEEF in cycle 6.
- Extension: mem 0x20=0x80, 0x21=0x01.
  - Signed byte load from 0x20 -> 0xFFFFFF80.
  - Unsigned byte load from 0x20 -> 0x00000080.
  - Signed half load from 0x20 -> 0xFFFF8001.
- Wrap-around (DATA_DIR_WIDTH=8): word store 0x11223344 at 0xFC -> bytes written to 0xFC–0xFF. A half load from 0xFE returns 0x00003344.
- Misaligned word load at 0x13:
  - With the macro: resp_err=1 in cycle 1 and no MemRead.
  - Without the macro: load from 0x10, resp_err=0.
- Reset mid-request: drop rst during ACCESS beat 2 of a word store -> only 2 bytes written, no resp_valid, and req_ready=1 the cycle after rst rises.
